ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Two-requester round-robin arbiter that time-shares one 64x8 single-port synchronous RAM (registered read address, write-or-read per cycle) between ports A and B.
- Sits between two client blocks and the RAM instance.
- Drives the RAM data/addr/we pins.
- Returns read data to the owning port with a fixed latency and a valid strobe.

Parameters:
- DATA_W, 8, data width of RAM word and client data buses.
- ADDR_W, 6, address width (RAM depth 2**ADDR_W = 64).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- a_req  input  1  port A request; command fields must be stable while a_req=1 and a_gnt=0.
- a_we  input  1  port A: 1=write, 0=read.
- a_addr  input  ADDR_W  port A address.
- a_wdata  input  DATA_W  port A write data.
- a_gnt  output  1  port A command accepted this cycle.
- a_rvalid  output  1  port A read data valid (one-cycle pulse).
- a_rdata  output  DATA_W  port A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as port A, for port B.
- ram_data  output  DATA_W  to RAM data input.
- ram_addr  output  ADDR_W  to RAM address.
- ram_we  output  1  to RAM write enable.
- ram_q  input  DATA_W  from RAM output; valid the cycle after a read address is presented.

Behaviour:
- Reset: rst=1 at a rising edge clears all state.
  - Priority pointer → A.
  - Read pipeline flags cleared; any in-flight read is dropped, with no rvalid.
  - a_rdata/b_rdata → 0.
- While rst=1: a_gnt=b_gnt=0 and ram_we=0.
- Grant (combinational from req and pointer):
  - Only one req high → that port is granted.
  - Both high → the port the pointer favours is granted.
  - Neither high → no grant, ram_we=0, ram_addr/ram_data hold the last granted values.
- Pointer update: at the edge ending a granted cycle, the pointer moves to the non-granted port. It is unchanged when there is no grant.
- Handshake:
  - gnt asserts in the same cycle the command is accepted; exactly one transaction per gnt cycle.
  - A requester holding req high after gnt issues a new command in the next cycle.
  - Under contention, grants alternate A,B,A,B.
- RAM drive in grant cycle N: ram_addr=granted addr, ram_data=granted wdata, ram_we=granted we.
- Write: committed at the end of cycle N; no response strobe.
- Read pipeline (per port, independent):
  - Stage 1: a read grant in cycle N sets rd_pend for that port at the end of N.
  - Stage 2: in cycle N+1 ram_q is valid; at the end of N+1 ram_q is captured into x_rdata and x_rvalid is set.
  - x_rvalid is high for exactly cycle N+2. Read latency = 2 cycles from gnt to rvalid.
  - x_rdata holds its value until the next read return for that port.
- Back-to-back reads are fully pipelined: one rvalid per cycle, in grant order. Ports A and B never receive rvalid in the same cycle.
- Write-then-read to the same address in consecutive grants, from either port, returns the new data.
- Read immediately after a write cycle: ram_q is only valid following a read-address cycle. rvalid data is always taken from ram_q in the cycle after that port's read grant.
- Reset mid-operation: outstanding reads are discarded. RAM contents are not cleared; the RAM has no reset.

Test Plan:
- Reset: assert rst 2 cycles with a_req=b_req=1 → a_gnt=b_gnt=0, ram_we=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0.
- Single port: A writes 0xA5 @ addr 3, then reads addr 3 → a_gnt each cycle, a_rvalid exactly 2 cycles after the read gnt with a_rdata=0xA5, b_rvalid stays 0.
- Contention: both req held, A writes 0x11 @ 5, B writes 0x22 @ 6, then both read their own address → grants A,B,A,B; a_rdata=0x11, b_rdata=0x22, rvalids 1 cycle apart.
- Fairness: both req held for 10 cycles after reset → exactly 5 grants each, strictly alternating, first grant to A.
- Cross-port coherency: B writes 0x7E @ 63, A reads 63 on the next grant → a_rdata=0x7E; addr 0 and 63 boundary writes and reads return the correct data.
- Reset mid-read: A read granted, rst asserted in cycle N+1 → no a_rvalid; after release, the next read of the same address returns the stored value.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter sharing one single-port synchronous RAM.
// One command per cycle reaches the RAM. Read data returns to the owning
// port two cycles after its grant, together with a one-cycle valid strobe.
module ram_port_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [DATA_W-1:0] ram_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } pri_t;

    pri_t              pri_q;
    pri_t              pri_d;
    logic [ADDR_W-1:0] addr_hold_q;
    logic [DATA_W-1:0] data_hold_q;
    logic              a_pend_q;
    logic              b_pend_q;

    // Priority pointer and last-granted address/data, so the RAM pins stay put when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            pri_q       <= PRI_A;
            addr_hold_q <= '0;
            data_hold_q <= '0;
        end else begin
            pri_q <= pri_d;
            if (a_gnt || b_gnt) begin
                addr_hold_q <= ram_addr;
                data_hold_q <= ram_data;
            end
        end
    end

    // Grant selection, RAM pin drive and next priority
    always_comb begin
        a_gnt    = 1'b0;
        b_gnt    = 1'b0;
        pri_d    = pri_q;
        ram_addr = addr_hold_q;
        ram_data = data_hold_q;
        ram_we   = 1'b0;
        if (!rst) begin
            if (a_req && (!b_req || pri_q == PRI_A)) begin
                a_gnt = 1'b1;
            end else if (b_req) begin
                b_gnt = 1'b1;
            end
        end
        if (a_gnt) begin
            ram_addr = a_addr;
            ram_data = a_wdata;
            ram_we   = a_we;
            pri_d    = PRI_B;
        end else if (b_gnt) begin
            ram_addr = b_addr;
            ram_data = b_wdata;
            ram_we   = b_we;
            pri_d    = PRI_A;
        end
    end

    // Per-port read pipeline: pending flag after the grant, capture of ram_q one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            a_pend_q <= 1'b0;
            b_pend_q <= 1'b0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_pend_q <= a_gnt && !a_we;
            b_pend_q <= b_gnt && !b_we;
            a_rvalid <= a_pend_q;
            b_rvalid <= b_pend_q;
            if (a_pend_q) begin
                a_rdata <= ram_q;
            end
            if (b_pend_q) begin
                b_rdata <= ram_q;
            end
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, shadow memory scoreboard for
// read returns, and one task per scenario with inline checks.
module tb_ram_port_arbiter;

    typedef struct packed {
        logic       we;
        logic [5:0] addr;
        logic [7:0] data;
    } cmd_t;

    typedef struct packed {
        int unsigned cyc;
        logic [7:0]  data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_req, a_we, b_req, b_we;
    logic [5:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [7:0] a_rdata, b_rdata;
    logic [7:0] ram_data;
    logic [5:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_q;

    logic [7:0]  mem    [64];
    logic [7:0]  shadow [64];
    exp_t        sb_a[$];
    exp_t        sb_b[$];
    cmd_t        cmd_a[$];
    cmd_t        cmd_b[$];
    int          gseq[$];
    int unsigned cyc = 0;
    int unsigned last_a_rv_cyc = 0;
    int unsigned last_b_rv_cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    ram_port_arbiter #(.DATA_W(8), .ADDR_W(6)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_data(ram_data), .ram_addr(ram_addr), .ram_we(ram_we), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    // Single-port RAM: write on we, read data registered one cycle after the address
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
        cyc   <= cyc + 1;
    end

    // Scoreboard: shadow memory on grants, expected returns queued per port
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb_a.delete();
            sb_b.delete();
        end else begin
            if (a_rvalid) begin
                n_checks++;
                last_a_rv_cyc = cyc;
                if (sb_a.size() == 0) begin
                    n_errors++;
                    $display("FAIL a_rvalid_unexpected: cycle %0d, a_rvalid=1 with no read outstanding", cyc);
                end else begin
                    e = sb_a.pop_front();
                    if (a_rdata !== e.data || cyc !== e.cyc) begin
                        n_errors++;
                        $display("FAIL a_return: got data %h at cycle %0d, expected %h at cycle %0d",
                                 a_rdata, cyc, e.data, e.cyc);
                    end
                end
            end
            if (b_rvalid) begin
                n_checks++;
                last_b_rv_cyc = cyc;
                if (sb_b.size() == 0) begin
                    n_errors++;
                    $display("FAIL b_rvalid_unexpected: cycle %0d, b_rvalid=1 with no read outstanding", cyc);
                end else begin
                    e = sb_b.pop_front();
                    if (b_rdata !== e.data || cyc !== e.cyc) begin
                        n_errors++;
                        $display("FAIL b_return: got data %h at cycle %0d, expected %h at cycle %0d",
                                 b_rdata, cyc, e.data, e.cyc);
                    end
                end
            end
            if (a_rvalid && b_rvalid) begin
                n_errors++;
                $display("FAIL rvalid_overlap: both rvalids high at cycle %0d, expected at most one", cyc);
            end
            if (a_gnt) begin
                if (a_we) shadow[a_addr] = a_wdata;
                else sb_a.push_back('{cyc: cyc + 2, data: shadow[a_addr]});
            end
            if (b_gnt) begin
                if (b_we) shadow[b_addr] = b_wdata;
                else sb_b.push_back('{cyc: cyc + 2, data: shadow[b_addr]});
            end
        end
    end

    task automatic do_reset();
        rst   = 1'b1;
        a_req = 1'b0;
        b_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Present queued commands, advancing a port's queue on each of its grants
    task automatic run_cmds(input int unsigned max_cyc);
        gseq.delete();
        for (int unsigned i = 0; i < max_cyc; i++) begin
            a_req = (cmd_a.size() != 0);
            b_req = (cmd_b.size() != 0);
            if (a_req) begin
                a_we = cmd_a[0].we; a_addr = cmd_a[0].addr; a_wdata = cmd_a[0].data;
            end
            if (b_req) begin
                b_we = cmd_b[0].we; b_addr = cmd_b[0].addr; b_wdata = cmd_b[0].data;
            end
            @(negedge clk);
            n_checks++;
            if ((a_gnt && b_gnt) || (a_gnt && !a_req) || (b_gnt && !b_req) ||
                ((a_req || b_req) && !a_gnt && !b_gnt)) begin
                n_errors++;
                $display("FAIL grant_legal: req=%b%b gnt=%b%b, expected exactly one grant to a requester",
                         a_req, b_req, a_gnt, b_gnt);
            end
            if (a_gnt) begin gseq.push_back(0); void'(cmd_a.pop_front()); end
            if (b_gnt) begin gseq.push_back(1); void'(cmd_b.pop_front()); end
            @(posedge clk); #1;
            a_req = 1'b0;
            b_req = 1'b0;
            if (cmd_a.size() == 0 && cmd_b.size() == 0 && sb_a.size() == 0 && sb_b.size() == 0) break;
        end
        a_req = 1'b0;
        b_req = 1'b0;
        n_checks++;
        if (cmd_a.size() + cmd_b.size() + sb_a.size() + sb_b.size() != 0) begin
            n_errors++;
            $display("FAIL run_timeout: %0d commands and %0d reads left, expected 0 and 0",
                     cmd_a.size() + cmd_b.size(), sb_a.size() + sb_b.size());
            cmd_a.delete(); cmd_b.delete();
        end
    endtask

    task automatic check_alternating(input string name, input int n, input int first);
        n_checks++;
        if (gseq.size() != n) begin
            n_errors++;
            $display("FAIL %s_count: got %0d grants, expected %0d", name, gseq.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                n_checks++;
                if (gseq[i] != ((first + i) % 2)) begin
                    n_errors++;
                    $display("FAIL %s_order: grant %0d went to port %0d, expected %0d",
                             name, i, gseq[i], (first + i) % 2);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_req = 1'b1; a_we = 1'b1; a_addr = 6'd1; a_wdata = 8'hFF;
        b_req = 1'b1; b_we = 1'b1; b_addr = 6'd2; b_wdata = 8'hEE;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({a_gnt, b_gnt, ram_we, a_rvalid, b_rvalid} !== 5'b00000) begin
                n_errors++;
                $display("FAIL reset_ctrl: gnt/we/rvalid=%b, expected 00000",
                         {a_gnt, b_gnt, ram_we, a_rvalid, b_rvalid});
            end
            n_checks++;
            if (a_rdata !== 8'h00 || b_rdata !== 8'h00) begin
                n_errors++;
                $display("FAIL reset_rdata: a_rdata=%h b_rdata=%h, expected 00 00", a_rdata, b_rdata);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; a_req = 1'b0; b_req = 1'b0;
    endtask

    task automatic test_single_port();
        a_req = 1'b1; a_we = 1'b1; a_addr = 6'd3; a_wdata = 8'hA5;
        @(negedge clk);
        n_checks++;
        if (!(a_gnt === 1'b1 && b_gnt === 1'b0 && ram_we === 1'b1 && ram_addr === 6'd3 && ram_data === 8'hA5)) begin
            n_errors++;
            $display("FAIL single_write: gnt=%b%b we=%b addr=%0d data=%h, expected 10 1 3 a5",
                     a_gnt, b_gnt, ram_we, ram_addr, ram_data);
        end
        @(posedge clk); #1;
        a_we = 1'b0; a_wdata = 8'h5A;
        @(negedge clk);
        n_checks++;
        if (!(a_gnt === 1'b1 && ram_we === 1'b0 && ram_addr === 6'd3)) begin
            n_errors++;
            $display("FAIL single_read_gnt: gnt=%b we=%b addr=%0d, expected 1 0 3", a_gnt, ram_we, ram_addr);
        end
        @(posedge clk); #1;
        a_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (!(a_rvalid === 1'b0 && a_gnt === 1'b0 && ram_we === 1'b0 && ram_addr === 6'd3 && ram_data === 8'h5A)) begin
            n_errors++;
            $display("FAIL single_idle: rvalid=%b gnt=%b we=%b addr=%0d data=%h, expected 0 0 0 3 5a",
                     a_rvalid, a_gnt, ram_we, ram_addr, ram_data);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (!(a_rvalid === 1'b1 && a_rdata === 8'hA5 && b_rvalid === 1'b0)) begin
            n_errors++;
            $display("FAIL single_return: a_rvalid=%b a_rdata=%h b_rvalid=%b, expected 1 a5 0",
                     a_rvalid, a_rdata, b_rvalid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (!(a_rvalid === 1'b0 && a_rdata === 8'hA5)) begin
            n_errors++;
            $display("FAIL single_hold: a_rvalid=%b a_rdata=%h, expected 0 a5", a_rvalid, a_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_contention();
        do_reset();
        cmd_a.push_back('{we: 1'b1, addr: 6'd5, data: 8'h11});
        cmd_a.push_back('{we: 1'b0, addr: 6'd5, data: 8'h00});
        cmd_b.push_back('{we: 1'b1, addr: 6'd6, data: 8'h22});
        cmd_b.push_back('{we: 1'b0, addr: 6'd6, data: 8'h00});
        run_cmds(20);
        check_alternating("contention", 4, 0);
        n_checks++;
        if (a_rdata !== 8'h11 || b_rdata !== 8'h22) begin
            n_errors++;
            $display("FAIL contention_data: a_rdata=%h b_rdata=%h, expected 11 22", a_rdata, b_rdata);
        end
        n_checks++;
        if (last_b_rv_cyc - last_a_rv_cyc != 1) begin
            n_errors++;
            $display("FAIL contention_spacing: b_rvalid %0d cycles after a_rvalid, expected 1",
                     last_b_rv_cyc - last_a_rv_cyc);
        end
    endtask

    task automatic test_fairness();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cmd_a.push_back('{we: 1'b0, addr: 6'd5, data: 8'h00});
            cmd_b.push_back('{we: 1'b0, addr: 6'd6, data: 8'h00});
        end
        run_cmds(30);
        check_alternating("fairness", 10, 0);
    endtask

    task automatic test_back_to_back_coherency();
        do_reset();
        cmd_a.push_back('{we: 1'b1, addr: 6'd0,  data: 8'h3C});
        cmd_a.push_back('{we: 1'b0, addr: 6'd63, data: 8'h00});
        cmd_b.push_back('{we: 1'b1, addr: 6'd63, data: 8'h7E});
        cmd_b.push_back('{we: 1'b0, addr: 6'd0,  data: 8'h00});
        run_cmds(20);
        check_alternating("coherency", 4, 0);
        n_checks++;
        if (a_rdata !== 8'h7E || b_rdata !== 8'h3C) begin
            n_errors++;
            $display("FAIL coherency_data: a_rdata=%h b_rdata=%h, expected 7e 3c", a_rdata, b_rdata);
        end
    endtask

    task automatic test_reset_mid_read();
        a_req = 1'b1; a_we = 1'b0; a_addr = 6'd3; a_wdata = 8'h00;
        @(negedge clk);
        n_checks++;
        if (a_gnt !== 1'b1) begin
            n_errors++;
            $display("FAIL midrst_gnt: a_gnt=%b, expected 1", a_gnt);
        end
        @(posedge clk); #1;
        a_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || a_rdata !== 8'h00) begin
                n_errors++;
                $display("FAIL midrst_drop: a_rvalid=%b b_rvalid=%b a_rdata=%h, expected 0 0 00",
                         a_rvalid, b_rvalid, a_rdata);
            end
            @(posedge clk); #1;
        end
        cmd_a.push_back('{we: 1'b0, addr: 6'd3, data: 8'h00});
        run_cmds(10);
        n_checks++;
        if (a_rdata !== 8'hA5) begin
            n_errors++;
            $display("FAIL midrst_reread: a_rdata=%h, expected a5", a_rdata);
        end
    endtask

    initial begin
        rst = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        test_reset();
        test_single_port();
        test_contention();
        test_fairness();
        test_back_to_back_coherency();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

endmodule
